// File: rtl/rgb_wheel_pkg.sv
// Shared types and helpers for the RGB colour-wheel receive monitor.
// Lit vector bit order is {red, green, blue}, 1 = lit.
package rgb_wheel_pkg;

  typedef logic [2:0] sector_t;

  typedef enum logic {
    ST_ACQUIRE,
    ST_TRACK
  } state_t;

  localparam sector_t SECTOR_INVALID = 3'd7;

  localparam logic [2:0] LIT_RED = 3'b100;
  localparam logic [2:0] LIT_YEL = 3'b110;
  localparam logic [2:0] LIT_GRN = 3'b010;
  localparam logic [2:0] LIT_CYN = 3'b011;
  localparam logic [2:0] LIT_BLU = 3'b001;
  localparam logic [2:0] LIT_MAG = 3'b101;

  function automatic sector_t lit_to_sector(
    input logic [2:0] lit
  );
    sector_t s;
    unique case (1'b1)
      (lit == LIT_RED): s = 3'd0;
      (lit == LIT_YEL): s = 3'd1;
      (lit == LIT_GRN): s = 3'd2;
      (lit == LIT_CYN): s = 3'd3;
      (lit == LIT_BLU): s = 3'd4;
      (lit == LIT_MAG): s = 3'd5;
      default:          s = SECTOR_INVALID;
    endcase
    return s;
  endfunction

  // Invalid has no successor; it maps to itself.
  function automatic sector_t next_sector(
    input sector_t s
  );
    sector_t n;
    if (s == 3'd5)
      n = 3'd0;
    else if (s > 3'd5)
      n = SECTOR_INVALID;
    else
      n = s + 3'd1;
    return n;
  endfunction

endpackage

// File: rtl/rgb_wheel_decoder_filter.sv
// 2-flop synchroniser plus stability filter for the active-low RGB lines.
// Emits the lit code and a one-cycle accept strobe after FILTER_CYCLES stable samples.
module rgb_sync_filter #(
  parameter int W             = 3,
  parameter int FILTER_CYCLES = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] lines_n,
  output logic [W-1:0] code,
  output logic         accept
);

  localparam int CW = $clog2(FILTER_CYCLES + 1);
  localparam logic [CW-1:0] F_MAX = CW'(FILTER_CYCLES);

  logic [W-1:0]  s1;
  logic [W-1:0]  s2;
  logic [W-1:0]  cand;
  logic [W-1:0]  acc;
  logic [CW-1:0] cnt;
  logic [CW-1:0] run;

  assign code = ~s2;

  // Length of the current run of identical samples, including this one.
  always_comb begin
    run = CW'(1);
    if (code == cand)
      run = (cnt == F_MAX) ? cnt : cnt + CW'(1);
  end

  assign accept = (code != acc) && (run == F_MAX);

  // Synchroniser flops idle unlit; the filter tracks candidate and accepted code.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= '1;
      s2   <= '1;
      cand <= '0;
      acc  <= '0;
      cnt  <= '0;
    end else begin
      s1   <= lines_n;
      s2   <= s1;
      cand <= code;
      cnt  <= run;
      if (accept)
        acc <= code;
    end
  end

endmodule

// File: rtl/rgb_wheel_decoder.sv
// Colour-wheel receive monitor: sector decode, dwell timing, record port, health flags.
// Optional macro RGB_DECODER_ORDER_CHECK_EN enables the sector-order checker.
module rgb_wheel_decoder
  import rgb_wheel_pkg::*;
#(
  parameter int CLK_HZ        = 12000000,
  parameter int FILTER_CYCLES = 16,
  parameter int CNT_W         = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rgb_r_n,
  input  logic             rgb_g_n,
  input  logic             rgb_b_n,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [2:0]       rec_sector,
  output logic [CNT_W-1:0] rec_dwell,
  output logic [2:0]       cur_sector,
  output logic             locked,
  input  logic             clr_flags,
  output logic             overrun,
  output logic             invalid_seen,
  output logic             order_err
);

  if (FILTER_CYCLES < 1 || CLK_HZ < 1) begin : g_bad_cfg
    $error("rgb_wheel_decoder: FILTER_CYCLES and CLK_HZ must be >= 1");
  end

  localparam logic [CNT_W-1:0] DWELL_MAX = '1;

  logic [2:0]       code;
  logic             accept;
  sector_t          new_sec;
  state_t           state;
  logic [CNT_W-1:0] dwell;
  logic             load;
  logic             drop;

  rgb_sync_filter #(
    .W             (3),
    .FILTER_CYCLES (FILTER_CYCLES)
  ) u_filter (
    .clk     (clk),
    .rst     (rst),
    .lines_n ({rgb_r_n, rgb_g_n, rgb_b_n}),
    .code    (code),
    .accept  (accept)
  );

  assign new_sec = lit_to_sector(code);
  assign load    = accept && (state == ST_TRACK);
  assign drop    = load && rec_valid && !rec_ready;

  // Acquire/track FSM with the current sector and its saturating dwell count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_ACQUIRE;
      cur_sector <= SECTOR_INVALID;
      dwell      <= '0;
      locked     <= 1'b0;
    end else begin
      unique case (state)
        ST_ACQUIRE: begin
          if (accept && new_sec != SECTOR_INVALID) begin
            state      <= ST_TRACK;
            cur_sector <= new_sec;
            dwell      <= CNT_W'(1);
            locked     <= 1'b1;
          end
        end
        ST_TRACK: begin
          if (accept) begin
            cur_sector <= new_sec;
            dwell      <= CNT_W'(1);
          end else if (dwell != DWELL_MAX) begin
            dwell <= dwell + CNT_W'(1);
          end
        end
        default: state <= ST_ACQUIRE;
      endcase
    end
  end

  // Single-entry record register; a held record is never overwritten.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rec_valid  <= 1'b0;
      rec_sector <= '0;
      rec_dwell  <= '0;
    end else if (load && !drop) begin
      rec_valid  <= 1'b1;
      rec_sector <= cur_sector;
      rec_dwell  <= dwell;
    end else if (rec_valid && rec_ready) begin
      rec_valid  <= 1'b0;
    end
  end

  // Sticky health flags; a set event beats a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun      <= 1'b0;
      invalid_seen <= 1'b0;
    end else begin
      overrun      <= drop | (overrun & ~clr_flags);
      invalid_seen <= (load && new_sec == SECTOR_INVALID)
                    | (invalid_seen & ~clr_flags);
    end
  end

`ifdef RGB_DECODER_ORDER_CHECK_EN
  logic ord_hit;

  assign ord_hit = load && (cur_sector == SECTOR_INVALID ||
                            new_sec != next_sector(cur_sector));

  // Sticky flag for any step that is not the next sector around the wheel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      order_err <= 1'b0;
    else
      order_err <= ord_hit | (order_err & ~clr_flags);
  end
`else
  assign order_err = 1'b0;
`endif

endmodule

// File: tb/tb_rgb_wheel_decoder.sv
// Self-checking bench for rgb_wheel_decoder: per-cycle reference model plus directed checks.
// Build with or without RGB_DECODER_ORDER_CHECK_EN.
module tb_rgb_wheel_decoder;

  localparam int FC  = 16;
  localparam int CW  = 11;
  localparam int MAX = (1 << CW) - 1;
`ifdef RGB_DECODER_ORDER_CHECK_EN
  localparam bit ORD = 1'b1;
`else
  localparam bit ORD = 1'b0;
`endif

  logic          clk = 0;
  logic          rst;
  logic          rgb_r_n, rgb_g_n, rgb_b_n;
  logic          rec_valid, rec_ready;
  logic [2:0]    rec_sector, cur_sector;
  logic [CW-1:0] rec_dwell;
  logic          locked, clr_flags;
  logic          overrun, invalid_seen, order_err;

  rgb_wheel_decoder #(
    .CLK_HZ        (12000000),
    .FILTER_CYCLES (FC),
    .CNT_W         (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rgb_r_n      (rgb_r_n),
    .rgb_g_n      (rgb_g_n),
    .rgb_b_n      (rgb_b_n),
    .rec_valid    (rec_valid),
    .rec_ready    (rec_ready),
    .rec_sector   (rec_sector),
    .rec_dwell    (rec_dwell),
    .cur_sector   (cur_sector),
    .locked       (locked),
    .clr_flags    (clr_flags),
    .overrun      (overrun),
    .invalid_seen (invalid_seen),
    .order_err    (order_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // lit code -> sector, and sector -> lit code
  int         lut  [8] = '{7, 4, 2, 3, 0, 5, 1, 7};
  logic [2:0] lits [6] = '{3'b100, 3'b110, 3'b010,
                           3'b011, 3'b001, 3'b101};

  // accepted records (handshakes) as seen by the model
  int q_s[$];
  int q_d[$];

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // model state
  int p1, p2, samp, last, run, acc;
  int cur, dw, ms, md;
  bit lk, mv, ov, iv, oe;

  task automatic model_reset();
    p1 = 0; p2 = 0; samp = 0; last = 0; run = 0; acc = 0;
    cur = 7; dw = 0; ms = 0; md = 0;
    lk = 0; mv = 0; ov = 0; iv = 0; oe = 0;
  endtask

  task automatic model_step();
    logic [2:0] l;
    bit acc_now, hs, load, drop, iv_set, oe_set;
    int ns, ls, ld;
    load = 0; iv_set = 0; oe_set = 0; ls = 0; ld = 0;
    l = ~{rgb_r_n, rgb_g_n, rgb_b_n};
    samp = p2; p2 = p1; p1 = int'(l);
    if (samp == last) run++;
    else run = 1;
    last = samp;
    acc_now = (samp != acc) && (run >= FC);
    hs = mv && rec_ready;
    if (hs) begin
      q_s.push_back(ms);
      q_d.push_back(md);
    end
    if (acc_now) begin
      acc = samp;
      ns = lut[samp];
      if (!lk) begin
        if (ns != 7) begin
          lk = 1; cur = ns; dw = 1;
        end
      end else begin
        load = 1; ls = cur; ld = dw;
        if (ns == 7) iv_set = 1;
        if (cur == 7 || ns == 7 || ns != (cur + 1) % 6) oe_set = 1;
        cur = ns; dw = 1;
      end
    end else if (lk && dw < MAX) begin
      dw++;
    end
    drop = load && mv && !rec_ready;
    if (load && !drop) begin
      mv = 1; ms = ls; md = ld;
    end else if (hs) begin
      mv = 0;
    end
    ov = drop || (ov && !clr_flags);
    iv = iv_set || (iv && !clr_flags);
    oe = (ORD && oe_set) || (oe && !clr_flags);
  endtask

  int nprint = 0;

  // compare DUT against the model every cycle out of reset
  always @(posedge clk) begin
    if (rst) begin
      model_reset();
    end else begin
      model_step();
      #1;
      n_tests++;
      if (rec_valid !== mv || (mv && (rec_sector !== 3'(ms) ||
          rec_dwell !== CW'(md))) || cur_sector !== 3'(cur) ||
          locked !== lk || overrun !== ov ||
          invalid_seen !== iv || order_err !== oe) begin
        n_fail++;
        if (nprint < 20) begin
          nprint++;
          $display("FAIL cycle t=%0t: got v%0d s%0d d%0d c%0d l%0d o%0d i%0d e%0d expected v%0d s%0d d%0d c%0d l%0d o%0d i%0d e%0d",
                   $time, rec_valid, rec_sector, rec_dwell, cur_sector,
                   locked, overrun, invalid_seen, order_err,
                   mv, ms, md, cur, lk, ov, iv, oe);
        end
      end
    end
  end

  task automatic put(input logic [2:0] lit);
    @(negedge clk);
    {rgb_r_n, rgb_g_n, rgb_b_n} = ~lit;
  endtask

  task automatic drive(input logic [2:0] lit, input int n);
    put(lit);
    repeat (n - 1) @(negedge clk);
  endtask

  bit seen;

  initial begin
    rst = 1;
    {rgb_r_n, rgb_g_n, rgb_b_n} = 3'b111;
    rec_ready = 1;
    clr_flags = 0;
    repeat (3) @(negedge clk);
    check("rst_cur", cur_sector, 7);
    check("rst_valid", rec_valid, 0);
    check("rst_locked", locked, 0);
    check("rst_dwell", rec_dwell, 0);
    check("rst_flags", {overrun, invalid_seen, order_err}, 0);
    rst = 0;

    seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (rec_valid) seen = 1;
    end
    check("idle_valid", seen, 0);
    check("idle_locked", locked, 0);
    check("idle_cur", cur_sector, 7);

    // full wheel 0..5,0
    drive(lits[0], 1000);
    put(lits[1]);
    repeat (17) @(posedge clk);
    #1 check("lat_before", cur_sector, 0);
    @(posedge clk);
    #1 check("lat_cur", cur_sector, 1);
    check("lat_valid", rec_valid, 1);
    check("lat_sector", rec_sector, 0);
    check("lat_dwell", rec_dwell, 1000);
    repeat (982) @(negedge clk);
    for (int s = 2; s < 6; s++) drive(lits[s], 1000);
    drive(lits[0], 1000);
    check("wheel_count", q_s.size(), 6);
    for (int i = 0; i < 6 && i < q_s.size(); i++) begin
      check("wheel_sector", q_s[i], i);
      check("wheel_dwell", q_d[i], 1000);
    end
    check("wheel_order", order_err, 0);

    // glitch rejection and minimum accepted pulse
    q_s.delete(); q_d.delete();
    drive(lits[2], 10);
    drive(lits[0], 500);
    check("glitch_recs", q_s.size(), 0);
    check("glitch_cur", cur_sector, 0);
    drive(lits[1], 16);
    drive(lits[0], 100);
    check("pulse_recs", q_s.size(), 2);
    if (q_s.size() == 2) begin
      check("pulse_sector", q_s[1], 1);
      check("pulse_dwell", q_d[1], 16);
    end

    // back-pressure: hold first record, drop second, clear loses to set
    q_s.delete(); q_d.delete();
    @(negedge clk) rec_ready = 0;
    drive(lits[1], 100);
    put(lits[2]);
    repeat (17) @(negedge clk);
    clr_flags = 1;
    @(negedge clk) clr_flags = 0;
    check("drop_overrun", overrun, 1);
    check("drop_valid", rec_valid, 1);
    check("drop_sector", rec_sector, 0);
    check("drop_cur", cur_sector, 2);
    repeat (81) @(negedge clk);
    @(negedge clk) begin rec_ready = 1; clr_flags = 1; end
    @(negedge clk) clr_flags = 0;
    check("clr_overrun", overrun, 0);
    check("held_count", q_s.size(), 1);
    if (q_s.size() == 1) check("held_sector", q_s[0], 0);

    // skip and invalid code
    drive(lits[0], 100);
    @(negedge clk) clr_flags = 1;
    @(negedge clk) clr_flags = 0;
    check("clr_order", order_err, 0);
    check("clr_invalid", invalid_seen, 0);
    q_s.delete(); q_d.delete();
    drive(lits[2], 100);
    check("skip_order", order_err, 32'(ORD));
    drive(3'b000, 50);
    drive(lits[3], 100);
    check("inv_seen", invalid_seen, 1);
    check("inv_count", q_s.size(), 3);
    if (q_s.size() == 3) begin
      check("skip_sector", q_s[1], 2);
      check("skip_dwell", q_d[1], 100);
      check("inv_sector", q_s[2], 7);
      check("inv_dwell", q_d[2], 50);
    end

    // dwell saturation
    drive(lits[4], (1 << CW) + 5);
    drive(lits[5], 100);
    check("sat_sector", q_s[q_s.size()-1], 4);
    check("sat_dwell", q_d[q_d.size()-1], MAX);

    // asynchronous reset mid-sector
    @(negedge clk);
    #2 rst = 1;
    #1;
    check("arst_cur", cur_sector, 7);
    check("arst_valid", rec_valid, 0);
    check("arst_locked", locked, 0);
    check("arst_rec", {rec_sector, rec_dwell}, 0);
    check("arst_flags", {overrun, invalid_seen, order_err}, 0);
    @(negedge clk) rst = 0;
    check("post_rst_cur", cur_sector, 7);
    repeat (60) @(negedge clk);
    check("relock_cur", cur_sector, 5);
    check("relock_valid", rec_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
